inst_cache_burst: RTL

INST_CACHE_BURST -- requirements
Module: inst_cache_burst

---
 rtl/inst_cache_burst_pkg.sv | 15 +
 rtl/inst_cache_burst_line_store.sv | 59 +++++
 rtl/inst_cache_burst.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/inst_cache_burst_pkg.sv
// Shared CPU-side definitions for the instruction cache: refill FSM encoding and default geometry.
package inst_cache_burst_pkg;

    localparam int unsigned XLEN            = 32;
    localparam int unsigned DEF_INDEX_BITS  = 8;
    localparam int unsigned DEF_OFFSET_BITS = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DATA = 2'd2,
        FILL = 2'd3
    } state_t;

endpackage

// File: rtl/inst_cache_burst_line_store.sv
// Direct-mapped line storage: data words, tags and valid bits.
// Asynchronous lookup read, one write address shared by word and tag writes.
module icache_line_store
    import inst_cache_burst_pkg::*;
#(
    parameter int unsigned INDEX_BITS  = DEF_INDEX_BITS,
    parameter int unsigned OFFSET_BITS = DEF_OFFSET_BITS,
    parameter int unsigned TAG_BITS    = XLEN - DEF_INDEX_BITS - DEF_OFFSET_BITS - 2
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic [INDEX_BITS-1:0]  rd_index,
    input  logic [OFFSET_BITS-1:0] rd_offset,
    output logic [XLEN-1:0]        rd_data,
    output logic [TAG_BITS-1:0]    rd_tag,
    output logic                   rd_valid,
    input  logic [INDEX_BITS-1:0]  wr_index,
    input  logic [OFFSET_BITS-1:0] wr_offset,
    input  logic                   wr_word,
    input  logic [XLEN-1:0]        wr_data,
    input  logic                   wr_tag,
    input  logic [TAG_BITS-1:0]    wr_tag_val,
    input  logic                   set_valid,
    input  logic                   clear_all
);

    localparam int unsigned LINES = 1 << INDEX_BITS;
    localparam int unsigned WORDS = LINES << OFFSET_BITS;

    logic [XLEN-1:0]     data_mem [WORDS];
    logic [TAG_BITS-1:0] tag_mem  [LINES];
    logic [LINES-1:0]    valid_q;

    assign rd_data  = data_mem[{rd_index, rd_offset}];
    assign rd_tag   = tag_mem[rd_index];
    assign rd_valid = valid_q[rd_index];

    // Data and tag arrays carry no reset; only the valid bits qualify them.
    always_ff @(posedge clk) begin
        if (wr_word) begin
            data_mem[{wr_index, wr_offset}] <= wr_data;
        end
        if (wr_tag) begin
            tag_mem[wr_index] <= wr_tag_val;
        end
    end

    // A flush wins over a line being marked valid in the same cycle.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            valid_q <= '0;
        end else if (clear_all) begin
            valid_q <= '0;
        end else if (set_valid) begin
            valid_q[wr_index] <= 1'b1;
        end
    end

endmodule

// File: rtl/inst_cache_burst.sv
// Direct-mapped instruction cache with burst line refill from a memory interface.
// Hits return combinationally; a miss stalls the CPU until the line is filled and the lookup replays.
module inst_cache_burst
    import inst_cache_burst_pkg::*;
#(
    parameter int unsigned INDEX_BITS  = DEF_INDEX_BITS,
    parameter int unsigned OFFSET_BITS = DEF_OFFSET_BITS
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic [XLEN-1:0] pc,
    input  logic            pc_valid,
    output logic [XLEN-1:0] instruction,
    output logic            pc_wait_stop_choke,
    input  logic            flush,
    output logic            interface_enable,
    output logic [XLEN-1:0] interface_PC,
    input  logic            interface_ack,
    input  logic            interface_rvalid,
    input  logic [XLEN-1:0] interface_instruction,
    input  logic            interface_rlast,
    output logic [XLEN-1:0] hit_count,
    output logic [XLEN-1:0] miss_count
);

    localparam int unsigned LSB_BITS  = OFFSET_BITS + 2;
    localparam int unsigned LINE_BITS = XLEN - LSB_BITS;
    localparam int unsigned TAG_BITS  = LINE_BITS - INDEX_BITS;

    state_t                 state_q, state_d;
    logic [LINE_BITS-1:0]   line_q, line_d;
    logic [OFFSET_BITS-1:0] beat_q, beat_d;
    logic                   flush_pend_q, flush_pend_d;
    logic [XLEN-1:0]        hit_q, miss_q;

    logic [INDEX_BITS-1:0]  pc_index;
    logic [OFFSET_BITS-1:0] pc_offset;
    logic [TAG_BITS-1:0]    pc_tag;
    logic [TAG_BITS-1:0]    rd_tag;
    logic                   rd_valid;
    logic [XLEN-1:0]        rd_data;
    logic                   hit_c, miss_c;
    logic                   wr_word, wr_tag, set_valid;
    logic [1:0]             unused_pc_lsb;

    assign unused_pc_lsb = pc[1:0];
    assign pc_index      = pc[LSB_BITS +: INDEX_BITS];
    assign pc_offset     = pc[2 +: OFFSET_BITS];
    assign pc_tag        = pc[XLEN-1 -: TAG_BITS];

    icache_line_store #(
        .INDEX_BITS (INDEX_BITS),
        .OFFSET_BITS(OFFSET_BITS),
        .TAG_BITS   (TAG_BITS)
    ) u_store (
        .clk       (clk),
        .resetn    (resetn),
        .rd_index  (pc_index),
        .rd_offset (pc_offset),
        .rd_data   (rd_data),
        .rd_tag    (rd_tag),
        .rd_valid  (rd_valid),
        .wr_index  (line_q[INDEX_BITS-1:0]),
        .wr_offset (beat_q),
        .wr_word   (wr_word),
        .wr_data   (interface_instruction),
        .wr_tag    (wr_tag),
        .wr_tag_val(line_q[LINE_BITS-1 -: TAG_BITS]),
        .set_valid (set_valid),
        .clear_all (flush)
    );

    // Lookups are only served in IDLE; other states belong to the refill.
    assign hit_c  = pc_valid && (state_q == IDLE) && rd_valid && (rd_tag == pc_tag);
    assign miss_c = pc_valid && (state_q == IDLE) && !hit_c;

    assign instruction        = rd_data;
    assign pc_wait_stop_choke = (state_q != IDLE) || miss_c;
    assign interface_enable   = (state_q == REQ);
    assign interface_PC       = {line_q, {LSB_BITS{1'b0}}};
    assign hit_count          = hit_q;
    assign miss_count         = miss_q;

    always_comb begin
        state_d      = state_q;
        line_d       = line_q;
        beat_d       = beat_q;
        flush_pend_d = flush_pend_q;
        wr_word      = 1'b0;
        wr_tag       = 1'b0;
        set_valid    = 1'b0;
        case (state_q)
            IDLE: begin
                beat_d       = '0;
                flush_pend_d = 1'b0;
                if (miss_c) begin
                    line_d  = pc[XLEN-1:LSB_BITS];
                    state_d = REQ;
                end
            end
            REQ: begin
                if (flush) flush_pend_d = 1'b1;
                if (interface_ack) state_d = DATA;
            end
            DATA: begin
                if (flush) flush_pend_d = 1'b1;
                if (interface_rvalid) begin
                    wr_word = 1'b1;
                    beat_d  = beat_q + OFFSET_BITS'(1);
                    if (interface_rlast) state_d = FILL;
                end
            end
            FILL: begin
                // A flush seen during the refill leaves the line invalid so the replay misses.
                wr_tag    = 1'b1;
                set_valid = !(flush_pend_q || flush);
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q      <= IDLE;
            line_q       <= '0;
            beat_q       <= '0;
            flush_pend_q <= 1'b0;
            hit_q        <= '0;
            miss_q       <= '0;
        end else begin
            state_q      <= state_d;
            line_q       <= line_d;
            beat_q       <= beat_d;
            flush_pend_q <= flush_pend_d;
            if (hit_c)  hit_q  <= hit_q + XLEN'(1);
            if (miss_c) miss_q <= miss_q + XLEN'(1);
        end
    end

endmodule
